// File: rtl/bnn_pkg.sv
// Shared types and helpers for the BNN tile engine: FSM state, popcount and
// symmetric saturating add.
package bnn_pkg;

  localparam int ACC_W_DEF = 16;
  // Widest word popcount() accepts; callers zero-extend narrower words.
  localparam int POP_MAX_W = 1024;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic              sat;
    logic signed [31:0] val;
  } sat_res_t;

  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // Clamps a + b to [-lim, +lim]; sat reports that clamping happened.
  function automatic sat_res_t sat_add(input int a, input int b, input int lim);
    longint   s;
    sat_res_t r;
    s = longint'(a) + longint'(b);
    if (s > longint'(lim)) begin
      r.sat = 1'b1;
      r.val = lim;
    end else if (s < -longint'(lim)) begin
      r.sat = 1'b1;
      r.val = -lim;
    end else begin
      r.sat = 1'b0;
      r.val = 32'(s);
    end
    return r;
  endfunction

endpackage

// File: rtl/bnn_xnor_pe.sv
// One XNOR-popcount PE: masked +-1 dot-product contribution per beat and a
// saturating accumulator. o_acc_next/o_sat_next include the current beat.
module bnn_xnor_pe
  import bnn_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_en,
  input  logic                    i_first,
  input  logic [WORD_SIZE-1:0]    i_weight,
  input  logic [WORD_SIZE-1:0]    i_act,
  input  logic [WORD_SIZE-1:0]    i_mask,
  output logic signed [ACC_W-1:0] o_acc_next,
  output logic                    o_sat_next
);

  localparam int ACC_LIM = (1 << (ACC_W - 1)) - 1;

  logic [POP_MAX_W-1:0]    w_match_ext;
  logic [POP_MAX_W-1:0]    w_mask_ext;
  int                      w_contrib;
  sat_res_t                w_res;
  logic                    w_unused_hi;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_sat;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_match_ext = '0;
    w_mask_ext  = '0;
    w_match_ext[WORD_SIZE-1:0] = ~(i_weight ^ i_act) & i_mask;
    w_mask_ext[WORD_SIZE-1:0]  = i_mask;
    w_contrib  = 2 * popcount(w_match_ext) - popcount(w_mask_ext);
    w_res      = sat_add(i_first ? 0 : int'(r_acc), w_contrib, ACC_LIM);
    o_acc_next = w_res.val[ACC_W-1:0];
    o_sat_next = w_res.sat | (~i_first & r_sat);
  end

  // The clamp keeps val within ACC_W bits, so the upper bits carry no information.
  assign w_unused_hi = ^w_res.val[31:ACC_W];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_acc <= o_acc_next;
      r_sat <= o_sat_next;
    end
  end

endmodule

// File: rtl/bnn_tile_engine.sv
// Streaming XNOR-popcount tile engine: NUM_PES parallel PEs, valid/ready in and out.
// Define BNN_THRESHOLD_EN for the per-PE threshold bank; otherwise out_bits = (sum >= 0).
module bnn_tile_engine
  import bnn_pkg::*;
#(
  parameter int NUM_PES   = 64,
  parameter int WORD_SIZE = 64,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_WORDS = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [NUM_PES*WORD_SIZE-1:0] weights_flat,
  input  logic [WORD_SIZE-1:0]         activation,
  input  logic [WORD_SIZE-1:0]         mask,
  input  logic                         thr_we,
  input  logic [$clog2(NUM_PES)-1:0]   thr_addr,
  input  logic [ACC_W-1:0]             thr_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PES*ACC_W-1:0]     out_sums_flat,
  output logic [NUM_PES-1:0]           out_bits,
  output logic                         sat_flag,
  output logic                         len_err,
  input  logic                         clr_err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CNT_W-1:0]         r_beat_cnt;
  logic [CNT_W-1:0]         w_cnt_next;
  logic                     r_out_valid;
  logic [NUM_PES*ACC_W-1:0] r_sums;
  logic [NUM_PES-1:0]       r_bits;
  logic                     r_sat_flag;
  logic                     r_len_err;

  logic                     w_accept;
  logic                     w_first;
  logic                     w_force;
  logic                     w_close;
  logic                     w_len_evt;
  logic signed [ACC_W-1:0]  w_acc_next [NUM_PES];
  logic [NUM_PES-1:0]       w_sat_next;
  logic [NUM_PES*ACC_W-1:0] w_sums_next;
  logic [NUM_PES-1:0]       w_bits_next;

  assign in_ready  = ~r_out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_first   = (r_state == IDLE);
  assign w_force   = (r_beat_cnt == CNT_W'(MAX_WORDS - 1));
  assign w_close   = w_accept & (in_last | w_force);
  assign w_len_evt = w_accept & w_force & ~in_last;

  for (genvar i = 0; i < NUM_PES; i++) begin : g_pe
    bnn_xnor_pe #(
      .WORD_SIZE(WORD_SIZE),
      .ACC_W    (ACC_W)
    ) u_pe (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_en      (w_accept),
      .i_first   (w_first),
      .i_weight  (weights_flat[i*WORD_SIZE +: WORD_SIZE]),
      .i_act     (activation),
      .i_mask    (mask),
      .o_acc_next(w_acc_next[i]),
      .o_sat_next(w_sat_next[i])
    );
  end

  always_comb begin
    w_sums_next = '0;
    for (int i = 0; i < NUM_PES; i++) begin
      w_sums_next[i*ACC_W +: ACC_W] = w_acc_next[i];
    end
  end

`ifdef BNN_THRESHOLD_EN
  logic signed [ACC_W-1:0] r_thr [NUM_PES];

  // NOTE: the threshold bank is a small flop array, not a RAM, so it is reset
  // explicitly; a bit decision taken before any write then compares against 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PES; i++) r_thr[i] <= '0;
    end else if (thr_we && (int'(thr_addr) < NUM_PES)) begin
      r_thr[thr_addr] <= thr_data;
    end
  end

  // Reads the pre-write bank, so a write coinciding with a close takes effect next vector.
  always_comb begin
    w_bits_next = '0;
    for (int i = 0; i < NUM_PES; i++) begin
      w_bits_next[i] = (w_acc_next[i] >= r_thr[i]);
    end
  end
`else
  logic w_unused_thr;
  assign w_unused_thr = ^{thr_we, thr_addr, thr_data};

  always_comb begin
    w_bits_next = '0;
    for (int i = 0; i < NUM_PES; i++) begin
      w_bits_next[i] = ~w_acc_next[i][ACC_W-1];
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_beat_cnt;
    if (w_accept) begin
      if (w_close) begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end else begin
        w_state_next = ACCUM;
        w_cnt_next   = r_beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_cnt_next;
    end
  end

  // A close in the same cycle as a drain reloads, so out_valid stays high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_sums      <= '0;
      r_bits      <= '0;
      r_sat_flag  <= 1'b0;
    end else begin
      if (w_close) begin
        r_out_valid <= 1'b1;
        r_sums      <= w_sums_next;
        r_bits      <= w_bits_next;
        r_sat_flag  <= |w_sat_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len_err <= 1'b0;
    end else if (w_len_evt) begin
      r_len_err <= 1'b1;
    end else if (clr_err) begin
      r_len_err <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_sums_flat = r_sums;
  assign out_bits      = r_bits;
  assign sat_flag      = r_sat_flag;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_bnn_tile_engine.sv
// Directed bench for bnn_tile_engine: 4 PEs x 64-bit words, MAX_WORDS=4, with an
// ACC_W=16 instance and an ACC_W=8 instance sharing the stimulus.
module tb_bnn_tile_engine;

  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] LO  = 64'h0000_0000_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_last, out_ready, thr_we, clr_err;
  logic [255:0] weights_flat;
  logic [63:0]  activation, mask;
  logic [1:0]   thr_addr;
  logic [15:0]  thr_data;
  logic [7:0]   thr_data8;

  logic         in_ready, out_valid, sat_flag, len_err;
  logic [63:0]  out_sums_flat;
  logic [3:0]   out_bits;
  logic         in_ready8, out_valid8, sat8, len_err8;
  logic [31:0]  out_sums8;
  logic [3:0]   out_bits8;

  int errors = 0;
  int checks = 0;

  assign thr_data8 = thr_data[7:0];

  always #5 clk = ~clk;

  bnn_tile_engine #(.NUM_PES(4), .WORD_SIZE(64), .ACC_W(16), .MAX_WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .weights_flat(weights_flat), .activation(activation),
    .mask(mask), .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sums_flat(out_sums_flat),
    .out_bits(out_bits), .sat_flag(sat_flag), .len_err(len_err), .clr_err(clr_err)
  );

  bnn_tile_engine #(.NUM_PES(4), .WORD_SIZE(64), .ACC_W(8), .MAX_WORDS(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_last(in_last), .weights_flat(weights_flat), .activation(activation),
    .mask(mask), .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sums_flat(out_sums8),
    .out_bits(out_bits8), .sat_flag(sat8), .len_err(len_err8), .clr_err(clr_err)
  );

  task automatic set_beat(input logic [255:0] w, input logic [63:0] a,
                          input logic [63:0] m, input logic last);
    weights_flat = w;
    activation   = a;
    mask         = m;
    in_last      = last;
    in_valid     = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; thr_we = 1'b0; clr_err = 1'b0;
    weights_flat = '0; activation = '0; mask = '0; thr_addr = '0; thr_data = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_sums_flat !== 64'h0) begin errors++; $display("FAIL reset_sums: got %h expected 0", out_sums_flat); end
    checks++; if (out_bits !== 4'h0) begin errors++; $display("FAIL reset_bits: got %h expected 0", out_bits); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b expected 0", out_valid8); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %b expected 0", out_valid); end
    set_beat({4{ALL}}, ALL, ALL, 1'b1);
    tick();
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_sums_flat !== {4{16'd64}}) begin errors++; $display("FAIL single_sums: got %h expected %h", out_sums_flat, {4{16'd64}}); end
    checks++; if (out_bits !== 4'hF) begin errors++; $display("FAIL single_bits: got %h expected f", out_bits); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL single_sat: got %b expected 0", sat_flag); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_multi_beat();
    logic [255:0] w;
    w = {PAT ^ 64'hFFFF_FFFF_0000_0000, PAT ^ 64'h0000_0000_0000_00FF, PAT, ~PAT};
    for (int b = 0; b < 3; b++) begin
      set_beat(w, PAT, LO, b == 2);
      tick();
      if (b == 1) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL multi_mid_valid: got %b expected 0", out_valid); end
      end
    end
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL multi_valid: got %b expected 1", out_valid); end
    checks++; if (out_sums_flat !== {16'd96, 16'd48, 16'd96, 16'hFFA0}) begin errors++; $display("FAIL multi_sums: got %h expected %h", out_sums_flat, {16'd96, 16'd48, 16'd96, 16'hFFA0}); end
    checks++; if (out_bits !== 4'b1110) begin errors++; $display("FAIL multi_bits: got %b expected 1110", out_bits); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    set_beat({4{ALL}}, ALL, ALL, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_sums_flat !== {4{16'd64}}) begin errors++; $display("FAIL b2b_first: got v=%b %h expected v=1 %h", out_valid, out_sums_flat, {4{16'd64}}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
    set_beat({4{ALL}}, ALL, 64'h0, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_sums_flat !== 64'h0) begin errors++; $display("FAIL b2b_second: got v=%b %h expected v=1 0", out_valid, out_sums_flat); end
    set_beat(256'h0, ALL, ALL, 1'b1);
    tick();
    idle();
    checks++; if (out_valid !== 1'b1 || out_sums_flat !== {4{16'hFFC0}}) begin errors++; $display("FAIL b2b_third: got v=%b %h expected v=1 %h", out_valid, out_sums_flat, {4{16'hFFC0}}); end
    checks++; if (out_bits !== 4'h0) begin errors++; $display("FAIL b2b_bits: got %h expected 0", out_bits); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_beat({4{ALL}}, ALL, ALL, 1'b1);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    set_beat({4{ALL}}, ALL, 64'h0, 1'b1);
    tick();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
    checks++; if (out_sums_flat !== {4{16'd64}}) begin errors++; $display("FAIL bp_hold_sums: got %h expected %h", out_sums_flat, {4{16'd64}}); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    tick();
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_replace_valid: got %b expected 1", out_valid); end
    checks++; if (out_sums_flat !== 64'h0) begin errors++; $display("FAIL bp_replace_sums: got %h expected 0", out_sums_flat); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_len_err();
    for (int b = 0; b < 4; b++) begin
      set_beat({4{ALL}}, ALL, ALL, 1'b0);
      tick();
      if (b == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len_mid_valid: got %b expected 0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1 || out_sums_flat !== {4{16'd256}}) begin errors++; $display("FAIL len_close: got v=%b %h expected v=1 %h", out_valid, out_sums_flat, {4{16'd256}}); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_set: got %b expected 1", len_err); end
    set_beat({4{ALL}}, ALL, ALL, 1'b1);
    tick();
    idle();
    checks++; if (out_sums_flat !== {4{16'd64}}) begin errors++; $display("FAIL len_new_vector: got %h expected %h", out_sums_flat, {4{16'd64}}); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_sticky: got %b expected 1", len_err); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_err_clear: got %b expected 0", len_err); end
    for (int b = 0; b < 4; b++) begin
      set_beat({4{ALL}}, ALL, ALL, 1'b0);
      clr_err = (b == 3);
      tick();
    end
    idle();
    clr_err = 1'b0;
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_set_wins: got %b expected 1", len_err); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_err_clear2: got %b expected 0", len_err); end
  endtask

  task automatic test_threshold();
    logic [255:0] w8, w10;
    logic [3:0]   exp_lo;
    w8  = {ALL, ALL ^ 64'h0000_0000_0FFF_FFFF, ALL, ALL};
    w10 = {ALL, ALL ^ 64'h0000_0000_07FF_FFFF, ALL, ALL};
`ifdef BNN_THRESHOLD_EN
    exp_lo = 4'b1011;
`else
    exp_lo = 4'b1111;
`endif
    thr_we = 1'b1; thr_addr = 2'd2; thr_data = 16'd10;
    tick();
    thr_we = 1'b0;
    set_beat(w8, ALL, ALL, 1'b1);
    tick();
    checks++; if (out_sums_flat !== {16'd64, 16'd8, 16'd64, 16'd64}) begin errors++; $display("FAIL thr_sum8: got %h expected %h", out_sums_flat, {16'd64, 16'd8, 16'd64, 16'd64}); end
    checks++; if (out_bits !== exp_lo) begin errors++; $display("FAIL thr_bits8: got %b expected %b", out_bits, exp_lo); end
    set_beat(w10, ALL, ALL, 1'b1);
    thr_we = 1'b1; thr_data = 16'd11;
    tick();
    thr_we = 1'b0;
    checks++; if (out_sums_flat !== {16'd64, 16'd10, 16'd64, 16'd64}) begin errors++; $display("FAIL thr_sum10: got %h expected %h", out_sums_flat, {16'd64, 16'd10, 16'd64, 16'd64}); end
    checks++; if (out_bits !== 4'b1111) begin errors++; $display("FAIL thr_bits10_oldthr: got %b expected 1111", out_bits); end
    set_beat(w10, ALL, ALL, 1'b1);
    tick();
    idle();
    checks++; if (out_bits !== exp_lo) begin errors++; $display("FAIL thr_bits10_newthr: got %b expected %b", out_bits, exp_lo); end
    tick();
  endtask

  task automatic test_saturation();
    for (int b = 0; b < 4; b++) begin
      set_beat({4{ALL}}, ALL, ALL, b == 3);
      tick();
    end
    idle();
    checks++; if (out_valid8 !== 1'b1 || out_sums8 !== 32'h7F7F_7F7F) begin errors++; $display("FAIL sat_sums8: got v=%b %h expected v=1 7f7f7f7f", out_valid8, out_sums8); end
    checks++; if (sat8 !== 1'b1) begin errors++; $display("FAIL sat_flag8: got %b expected 1", sat8); end
    checks++; if (out_sums_flat !== {4{16'd256}} || sat_flag !== 1'b0) begin errors++; $display("FAIL sat_wide: got %h sat=%b expected %h sat=0", out_sums_flat, sat_flag, {4{16'd256}}); end
    tick();
    for (int b = 0; b < 2; b++) begin
      set_beat({4{ALL}}, ALL, ALL, 1'b0);
      tick();
    end
    idle();
    reset_n = 1'b0;
    #2;
    checks++; if (out_valid8 !== 1'b0 || out_sums8 !== 32'h0 || out_bits8 !== 4'h0) begin errors++; $display("FAIL sat_reset_out: got v=%b %h bits=%h expected v=0 0 0", out_valid8, out_sums8, out_bits8); end
    checks++; if (sat8 !== 1'b0 || len_err8 !== 1'b0 || in_ready8 !== 1'b1) begin errors++; $display("FAIL sat_reset_flags: got sat=%b len=%b rdy=%b expected 0 0 1", sat8, len_err8, in_ready8); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    set_beat({4{ALL}}, ALL, ALL, 1'b1);
    tick();
    idle();
    checks++; if (out_valid8 !== 1'b1 || out_sums8 !== 32'h4040_4040) begin errors++; $display("FAIL sat_fresh_sums: got v=%b %h expected v=1 40404040", out_valid8, out_sums8); end
    checks++; if (sat8 !== 1'b0) begin errors++; $display("FAIL sat_fresh_flag: got %b expected 0", sat8); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_beat();
    test_back_to_back();
    test_backpressure();
    test_len_err();
    test_threshold();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bnn_tile_engine.md
# bnn_tile_engine

Streaming XNOR-popcount tile engine; next-generation replacement for the flat PE array in the BNN datapath. Computes NUM_PES signed ±1 dot products over vectors spanning 1..MAX_WORDS words, one word per accepted beat. Activation and mask are broadcast, and weights are per PE. Results are presented on a valid/ready output with optional per-PE threshold binarisation. Sits between the weight/activation fetch stage and the next layer's activation buffer.

## Interface
- NUM_PES, 64, number of parallel PEs (output channels)
- WORD_SIZE, 64, bits per activation/weight word
- ACC_W, 16, signed accumulator/result width per PE
- MAX_WORDS, 16, maximum beats per vector
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept beat
- in_last  in  1  final word of current vector
- weights_flat  in  NUM_PES*WORD_SIZE  PE i weight word at [i*WORD_SIZE +: WORD_SIZE]
- activation  in  WORD_SIZE  broadcast activation word
- mask  in  WORD_SIZE  broadcast valid-bit mask (1 = bit counts)
- thr_we  in  1  threshold write strobe
- thr_addr  in  $clog2(NUM_PES)  PE index for threshold write
- thr_data  in  ACC_W  signed threshold value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sums_flat  out  NUM_PES*ACC_W  signed dot products, PE i at [i*ACC_W +: ACC_W]
- out_bits  out  NUM_PES  binarised result per PE
- sat_flag  out  1  sticky: some accumulator saturated in the vector currently on the output
- len_err  out  1  sticky: vector force-closed at MAX_WORDS
- clr_err  in  1  clears len_err

## Operation
- Per beat, per PE: contribution = 2*popcount(~(w ^ a) & mask) - popcount(mask), a signed value in [-WORD_SIZE, +WORD_SIZE].
- First beat of a vector loads acc = contribution. Later beats set acc = sat(acc + contribution), saturating at ±(2^(ACC_W-1)-1). Any saturation sets the vector's sat bit.
- A beat is accepted on cycle with in_valid && in_ready.
- in_ready = !out_valid || out_ready.
- FSM states:
  - IDLE: no vector open. An accepted beat moves to ACCUM, or to IDLE again if in_last.
  - ACCUM: vector open. An accepted last beat returns to IDLE.
- Closing beat (in_last, or beat count reaching MAX_WORDS):
  - Accumulated value including that beat is copied to the output registers, and out_valid is set.
  - If the beat count reaches MAX_WORDS without in_last, the vector is closed and len_err is set.
- out_valid clears on out_valid && out_ready, unless a closing beat is accepted the same cycle. In that case new results load and out_valid stays 1.
- Output registers are separate from the accumulators, so the next vector accumulates while the result is held.
- Thresholds: NUM_PES×ACC_W register bank, written when thr_we. thr_addr ≥ NUM_PES is ignored. out_bits[i] = (sum_i ≥ thr_i), computed at load time and registered with the sums.
- A threshold write in the same cycle as a closing beat uses the old threshold.
- len_err clears on clr_err. If clr_err coincides with a new len_err event, set wins.

## Timing
- Latency: the closing beat accepted at cycle t gives out_valid=1 and valid data at t+1.
- Throughput: one beat per cycle. Back-to-back single-beat vectors sustain one result per cycle when out_ready=1.
- Reset values:
  - out_valid=0, in_ready=1, out_sums_flat=0, out_bits=0, sat_flag=0, len_err=0.
  - Thresholds=0, FSM=IDLE, beat counter=0.
- Reset mid-vector discards the partial accumulation, with no output produced.
- out_sums_flat, out_bits and sat_flag are stable while out_valid && !out_ready.

## Configuration
- BNN_THRESHOLD_EN defined: threshold bank and out_bits logic present as above.
- BNN_THRESHOLD_EN undefined: no threshold registers. thr_we, thr_addr and thr_data are ignored. out_bits is tied to the sign bit inverted (sum ≥ 0).

## Structure
- Package bnn_pkg holds:
  - ACC_W default
  - FSM state enum (IDLE, ACCUM)
  - popcount function
  - signed saturating-add function
- Sub-module bnn_xnor_pe holds one PE's XNOR/mask/popcount, contribution and saturating accumulator, with first/valid controls. It is generated NUM_PES times.
- FSM, counter, output registers and threshold bank live in bnn_tile_engine.

## Test plan
Bench uses NUM_PES=4, WORD_SIZE=64, ACC_W=16, MAX_WORDS=4.
- Single beat, w=a=all-ones, mask=all-ones, in_last → sum=+64 for each PE, out_valid at t+1.
- Three beats, PE0 w=~a, mask=0x0000_0000_FFFF_FFFF each → PE0 sum=-96. PE1 with w=a → sum=+96.
- Backpressure: out_ready=0 holding a result → in_ready=0 once the next closing beat is pending. Held data is unchanged. out_ready=1 with a simultaneous closing beat → new result replaces the old, and out_valid stays 1.
- Five beats without in_last → closes at beat 4 with len_err=1. Beat 5 opens a new vector. clr_err clears len_err.
- Threshold: write thr[2]=10, then sum_2=+8 → out_bits[2]=0. Sum=+10 → out_bits[2]=1. Without BNN_THRESHOLD_EN, out_bits[2]=1 for sum=+8.
- Saturation with ACC_W=8, MAX_WORDS=4: four beats of +64 → sum=+127, sat_flag=1. Reset_n pulse mid-vector → all outputs 0, next vector starts fresh.
